rpn_sequencer: RTL and testbench

//  Program controller for the 16-bit RPN stack calculator (push/op/d/step interface, cnt/out status).

---
 rtl/rpn_sequencer.sv | 166 ++++++++++++++++
 tb/tb_rpn_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: program controller for the 16-bit RPN stack calculator.
// Fetches 18-bit instructions from ROM and issues depth-checked steps.
module rpn_sequencer #(
  parameter int PROG_DEPTH  = 256,
  parameter int STACK_DEPTH = 1000,
  parameter int PC_W        = $clog2(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [17:0]     imem_data,
  output logic            calc_clr,
  output logic            calc_step,
  output logic            calc_push,
  output logic [1:0]      calc_op,
  output logic [15:0]     calc_d,
  input  logic [9:0]      calc_cnt,
  input  logic [15:0]     calc_out,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [15:0]     result,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [9:0] MAX_CNT = 10'(STACK_DEPTH);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

  state_t state;

  logic [1:0] kind;
  logic [1:0] op;
  logic       is_push;
  logic       is_op;
  logic       is_halt;
  logic       is_rsv;
  logic       ovf;
  logic       unf;

  assign imem_addr = pc;

  always_comb begin
    kind    = imem_data[17:16];
    op      = imem_data[1:0];
    is_push = (kind == 2'b00);
    is_op   = (kind == 2'b01);
    is_halt = (kind == 2'b10);
    is_rsv  = (kind == 2'b11);
    ovf     = is_push && (calc_cnt >= MAX_CNT);
    // negate needs one operand, add/multiply need two
    unf     = is_op &&
              (((op == 2'd1) && (calc_cnt == 10'd0)) ||
               (op[1] && (calc_cnt < 10'd2)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      imem_rd   <= 1'b0;
      calc_clr  <= 1'b0;
      calc_step <= 1'b0;
      calc_push <= 1'b0;
      calc_op   <= 2'd0;
      calc_d    <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      result    <= 16'd0;
    end else begin
      calc_clr  <= 1'b0;
      calc_step <= 1'b0;
      imem_rd   <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            pc       <= '0;
            busy     <= 1'b1;
            calc_clr <= 1'b1;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          imem_rd <= 1'b1;
          state   <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          calc_push <= is_push;
          calc_op   <= is_op ? op : 2'd0;
          calc_d    <= imem_data[15:0];
          unique case (1'b1)
            is_halt: begin
              result <= calc_out;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end
            is_rsv: begin
              err      <= 1'b1;
              err_code <= 2'b11;
              busy     <= 1'b0;
              state    <= S_ERROR;
            end
            ovf: begin
              err      <= 1'b1;
              err_code <= 2'b10;
              busy     <= 1'b0;
              state    <= S_ERROR;
            end
            unf: begin
              err      <= 1'b1;
              err_code <= 2'b01;
              busy     <= 1'b0;
              state    <= S_ERROR;
            end
            default: begin
              calc_step <= 1'b1;
              state     <= S_EXEC;
            end
          endcase
        end
        S_EXEC: begin
          // running off the last ROM word aborts; pc stays put
          if (pc == LAST_PC) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            busy     <= 1'b0;
            state    <= S_ERROR;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          imem_rd <= 1'b1;
          state   <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: directed bench for rpn_sequencer.
// Small ROM and calculator model around a PROG_DEPTH=8, STACK_DEPTH=4 DUT.
module tb_rpn_sequencer;

  localparam int PD = 8;
  localparam int SD = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] imem_addr;
  logic          imem_rd;
  logic [17:0]   imem_data = 18'd0;
  logic          calc_clr;
  logic          calc_step;
  logic          calc_push;
  logic [1:0]    calc_op;
  logic [15:0]   calc_d;
  logic [9:0]    calc_cnt;
  logic [15:0]   calc_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [15:0]   result;
  logic [PW-1:0] pc;

  int checks = 0;
  int failures = 0;
  int n_step = 0;
  int n_clr = 0;
  int edges;
  int s0;
  int c0;

  logic [17:0] rom [PD];
  logic [15:0] stk [16];
  int          m_cnt = 0;

  always #5 clk = ~clk;

  rpn_sequencer #(
    .PROG_DEPTH (PD),
    .STACK_DEPTH(SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .imem_addr(imem_addr),
    .imem_rd  (imem_rd),
    .imem_data(imem_data),
    .calc_clr (calc_clr),
    .calc_step(calc_step),
    .calc_push(calc_push),
    .calc_op  (calc_op),
    .calc_d   (calc_d),
    .calc_cnt (calc_cnt),
    .calc_out (calc_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .result   (result),
    .pc       (pc)
  );

  always @(posedge clk) begin
    if (imem_rd) imem_data <= rom[imem_addr];
  end

  always @(posedge clk) begin
    if (calc_step) n_step <= n_step + 1;
    if (calc_clr) n_clr <= n_clr + 1;
  end

  // calculator: clr empties the stack, step pushes or applies op
  always @(posedge clk) begin
    if (calc_clr) begin
      m_cnt <= 0;
    end else if (calc_step) begin
      if (calc_push) begin
        if (m_cnt < 16) begin
          stk[m_cnt] <= calc_d;
          m_cnt <= m_cnt + 1;
        end
      end else begin
        case (calc_op)
          2'd1: if (m_cnt >= 1) stk[m_cnt-1] <= -stk[m_cnt-1];
          2'd2: if (m_cnt >= 2) begin
            stk[m_cnt-2] <= stk[m_cnt-2] + stk[m_cnt-1];
            m_cnt <= m_cnt - 1;
          end
          2'd3: if (m_cnt >= 2) begin
            stk[m_cnt-2] <= stk[m_cnt-2] * stk[m_cnt-1];
            m_cnt <= m_cnt - 1;
          end
          default: ;
        endcase
      end
    end
  end

  assign calc_cnt = 10'(m_cnt);
  assign calc_out = (m_cnt > 0) ? stk[m_cnt-1] : 16'h0000;

  function automatic logic [17:0] i_push(input logic [15:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [17:0] i_op(input logic [1:0] o);
    return {2'b01, 14'd0, o};
  endfunction

  localparam logic [17:0] I_HALT = {2'b10, 16'd0};
  localparam logic [17:0] I_RSV  = {2'b11, 16'd0};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input logic [17:0] w);
    for (int i = 0; i < PD; i++) rom[i] = w;
  endtask

  task automatic load_t1();
    fill_rom(I_HALT);
    rom[0] = i_push(16'd3);
    rom[1] = i_push(16'd4);
    rom[2] = i_op(2'd2);
    rom[3] = i_push(16'd5);
    rom[4] = i_op(2'd3);
    rom[5] = I_HALT;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(done || err) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    load_t1();
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_step", 32'(calc_step), 32'd0);
    check("rst_imem_rd", 32'(imem_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // T1
    s0 = n_step;
    pulse_start();
    wait_end(edges);
    check("t1_latency", 32'(edges), 32'd23);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_result", 32'(result), 32'd35);
    check("t1_steps", 32'(n_step - s0), 32'd5);
    check("t1_pc", 32'(pc), 32'd5);
    check("t1_busy", 32'(busy), 32'd0);

    // T2
    fill_rom(I_HALT);
    rom[0] = i_push(16'd7);
    rom[1] = i_op(2'd2);
    s0 = n_step;
    pulse_start();
    wait_end(edges);
    check("t2_err", 32'(err), 32'd1);
    check("t2_code", 32'(err_code), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_pc", 32'(pc), 32'd1);
    check("t2_steps", 32'(n_step - s0), 32'd1);
    rom[1] = i_push(16'd1);
    rom[2] = i_op(2'd2);
    c0 = n_clr;
    pulse_start();
    check("t2_err_clr", 32'(err), 32'd0);
    check("t2_calc_clr", 32'(calc_clr), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    wait_end(edges);
    check("t2_clr_pulses", 32'(n_clr - c0), 32'd1);
    check("t2_done2", 32'(done), 32'd1);
    check("t2_result2", 32'(result), 32'd8);

    // T3
    fill_rom(I_HALT);
    for (int i = 0; i < 5; i++) rom[i] = i_push(16'd1);
    s0 = n_step;
    pulse_start();
    wait_end(edges);
    check("t3_err", 32'(err), 32'd1);
    check("t3_code", 32'(err_code), 32'd2);
    check("t3_pc", 32'(pc), 32'd4);
    check("t3_cnt", 32'(calc_cnt), 32'd4);
    check("t3_steps", 32'(n_step - s0), 32'd4);

    // T4
    fill_rom(I_HALT);
    rom[0] = I_RSV;
    s0 = n_step;
    pulse_start();
    wait_end(edges);
    check("t4a_code", 32'(err_code), 32'd3);
    check("t4a_pc", 32'(pc), 32'd0);
    check("t4a_steps", 32'(n_step - s0), 32'd0);
    fill_rom(i_op(2'd0));
    s0 = n_step;
    pulse_start();
    wait_end(edges);
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_code", 32'(err_code), 32'd3);
    check("t4b_pc", 32'(pc), 32'd7);
    check("t4b_steps", 32'(n_step - s0), 32'd8);

    // T5
    fill_rom(I_HALT);
    rom[0] = i_push(16'd9);
    rom[1] = i_op(2'd1);
    c0 = n_clr;
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    wait_end(edges);
    check("t5_done", 32'(done), 32'd1);
    check("t5_result", 32'(result), 32'h0000FFF7);
    check("t5_clr_pulses", 32'(n_clr - c0), 32'd1);

    // T6
    load_t1();
    pulse_start();
    repeat (11) @(posedge clk);
    #1;
    check("t6_in_exec", 32'(calc_step), 32'd1);
    check("t6_exec_pc", 32'(pc), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_step", 32'(calc_step), 32'd0);
    check("t6_clr", 32'(calc_clr), 32'd0);
    check("t6_imem_rd", 32'(imem_rd), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_code", 32'(err_code), 32'd0);
    check("t6_result", 32'(result), 32'd0);
    check("t6_pc", 32'(pc), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_idle_stays", 32'(busy), 32'd0);
    pulse_start();
    wait_end(edges);
    check("t6_latency", 32'(edges), 32'd23);
    check("t6_done2", 32'(done), 32'd1);
    check("t6_result2", 32'(result), 32'd35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
